parity_serializer: RTL and testbench
====================================

// Module: parity_serializer
// PURPOSE
//  Upstream feeder for the serial even-parity checker: accepts a parallel word over valid/ready,
//  shifts it out one bit per clock LSB-first, then appends one even-parity bit.
//  Every complete frame therefore holds an even number of 1s.
//  A checker that starts from reset at even state returns to even (dout=1) after each frame.
// PARAMETERS
//  WIDTH  8  data word width in bits; legal range 2..32
// PORTS
//  clk        input   1      single clock, all state updates on posedge
//  rst        input   1      asynchronous reset, active-low
//  din        input   WIDTH  parallel data word
//  din_vld    input   1      din holds a valid word
//  din_rdy    output  1      block can accept a word this cycle
//  dout       output  1      serial bit to the parity checker
//  dout_vld   output  1      dout carries a frame bit this cycle
//  dout_last  output  1      dout carries the appended parity bit (last bit of frame)
// BEHAVIOUR
//  Reset (rst=0, async):
//   - state=S_IDLE; shift register, bit counter and parity accumulator cleared.
//   - Outputs: dout=0, dout_vld=0, dout_last=0, din_rdy=1.
//  Handshake:
//   - Accept occurs on a posedge with din_vld && din_rdy.
//   - din_rdy is combinational from state only: 1 in S_IDLE and S_PAR, 0 in S_DATA.
//   - No combinational path from din_vld to din_rdy.
//   - Downstream has no backpressure; the consumer takes one bit every cycle dout_vld=1.
//  FSM, states S_IDLE / S_DATA / S_PAR:
//   - S_IDLE: on accept, load shreg<=din, par<=^din, cnt<=0, go to S_DATA. Otherwise hold.
//   - S_DATA: dout=shreg[0], dout_vld=1, dout_last=0.
//     Each cycle: shreg shifts right, cnt increments.
//     When cnt==WIDTH-1, go to S_PAR.
//   - S_PAR: dout=par, dout_vld=1, dout_last=1.
//     With an accept this cycle: load the new word and go to S_DATA (zero-gap back-to-back).
//     Without an accept: go to S_IDLE.
//   - Illegal state encoding: return to S_IDLE.
//  Timing:
//   - Latency: word accepted at edge N; bit0 appears on dout in the cycle after edge N.
//   - Parity bit appears WIDTH cycles after bit0.
//   - Throughput: one word per WIDTH+1 cycles when din_vld is held high.
//  Widths and datapath:
//   - cnt width = $clog2(WIDTH); compare against WIDTH-1, no wrap reliance.
//   - par is the XOR of all WIDTH bits of the accepted word, fixed at accept.
//   - par is not recomputed from the shifting register.
//  Output drive: outputs are decoded from registered state/shreg/par only, no input-to-output path.
//  Boundary conditions:
//   - din changing or din_vld dropping during S_DATA: ignored; the captured word is unaffected.
//   - din_vld=1 in S_IDLE and S_PAR: accepted the same edge; exactly one word per accept.
//   - Reset mid-frame: frame abandoned immediately; dout_vld=0 asynchronously; no parity bit sent.
//     The downstream checker is reset by the same rst.
//   - din=0: frame of WIDTH zeros plus parity 0.
//   - din all-ones: parity = WIDTH[0].
// STRUCTURE
//  - Shared package parity_pkg holds: state encodings S_IDLE=2'd0, S_DATA=2'd1, S_PAR=2'd2,
//    and the default WIDTH constant.
//  - The even-parity checker uses the same package for its state constants.
//  - Single flat module: one sequential always block (async reset) for state/shreg/cnt/par,
//    one combinational block for next-state and outputs.
//  - No sub-module.
//  - The bench pairs this block with the even-parity checker as a golden consumer.
// TESTING (WIDTH=8 unless noted; checker dout sampled in the cycle after dout_last)
//  1. din=8'hA5, one accept
//     -> dout 1,0,1,0,0,1,0,1 then parity 0 with dout_last=1;
//     -> din_rdy=0 for 8 cycles; checker dout=1.
//  2. din=8'h07
//     -> bits 1,1,1,0,0,0,0,0 then parity 1;
//     -> checker dout=1 at frame end, 0 after bits 1 and 3.
//  3. din_vld held high with words 8'hFF, 8'h01, 8'h80
//     -> 27 consecutive dout_vld cycles, no gaps;
//     -> parities 0,1,1; dout_last pulses at cycles 9, 18, 27.
//  4. din_vld=1 with changing din during S_DATA
//     -> no accept, din_rdy=0;
//     -> original word shifted out unchanged.
//  5. rst low at the 4th data bit of 8'h3C
//     -> dout_vld, dout_last go 0 immediately; din_rdy=1;
//     -> next frame 8'h01 emits correct parity 1.
//  6. WIDTH=2, din=2'b11
//     -> bits 1,1, parity 0; frame length 3 cycles;
//     -> cnt never exceeds 1.

Source files
------------

// File: rtl/parity_pkg.sv
// Shared constants for the parity serializer and its downstream even-parity checker.
// Both blocks import this package.
package parity_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_PAR  = 2'd2
  } ser_state_t;

  typedef enum logic {
    C_EVEN = 1'b0,
    C_ODD  = 1'b1
  } chk_state_t;

  function automatic logic even_parity(input logic [31:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/even_parity_checker.sv
// Serial even-parity checker: dout is 1 while the number of 1s seen so far is even.
// It is the intended consumer of parity_serializer and is reset by the same rst.
module even_parity_checker
  import parity_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic din_vld,
  output logic dout
);

  chk_state_t r_state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= C_EVEN;
    end else if (din_vld && din) begin
      r_state <= (r_state == C_EVEN) ? C_ODD : C_EVEN;
    end
  end

  assign dout = (r_state == C_EVEN);

endmodule

// File: rtl/parity_serializer.sv
// Accepts a parallel word over valid/ready and emits it LSB-first, followed by one even-parity
// bit, so that every frame carries an even number of 1s.
module parity_serializer
  import parity_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_vld,
  output logic             din_rdy,
  output logic             dout,
  output logic             dout_vld,
  output logic             dout_last
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

  ser_state_t       r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CNT_W-1:0] r_cnt;
  logic             r_par;

  ser_state_t       w_state_nxt;
  logic [WIDTH-1:0] w_shreg_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_par_nxt;
  logic             w_accept;

  // Ready depends on state only, so din_vld never reaches din_rdy combinationally.
  assign din_rdy  = (r_state == S_IDLE) || (r_state == S_PAR);
  assign w_accept = din_vld && din_rdy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
      r_par   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_shreg <= w_shreg_nxt;
      r_cnt   <= w_cnt_nxt;
      r_par   <= w_par_nxt;
    end
  end

  // Parity is fixed at accept time; the shifting register is never re-reduced.
  always_comb begin
    w_state_nxt = r_state;
    w_shreg_nxt = r_shreg;
    w_cnt_nxt   = r_cnt;
    w_par_nxt   = r_par;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_shreg_nxt = din;
          w_par_nxt   = ^din;
          w_cnt_nxt   = '0;
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        w_shreg_nxt = r_shreg >> 1;
        if (r_cnt == CNT_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_PAR;
        end else begin
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      S_PAR: begin
        if (w_accept) begin
          w_shreg_nxt = din;
          w_par_nxt   = ^din;
          w_cnt_nxt   = '0;
          w_state_nxt = S_DATA;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_comb begin
    dout      = 1'b0;
    dout_vld  = 1'b0;
    dout_last = 1'b0;
    case (r_state)
      S_DATA: begin
        dout     = r_shreg[0];
        dout_vld = 1'b1;
      end
      S_PAR: begin
        dout      = r_par;
        dout_vld  = 1'b1;
        dout_last = 1'b1;
      end
      default: begin
        dout      = 1'b0;
        dout_vld  = 1'b0;
        dout_last = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_parity_serializer.sv
// Bench for parity_serializer paired with the even-parity checker as downstream consumer.
module tb_parity_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] din = '0;
  logic       din_vld = 1'b0;
  logic       din_rdy, dout, dout_vld, dout_last, chk_dout;

  logic [1:0] din2 = '0;
  logic       din2_vld = 1'b0;
  logic       din2_rdy, dout2, dout2_vld, dout2_last;

  always #5 clk = ~clk;

  parity_serializer #(.WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .din(din), .din_vld(din_vld), .din_rdy(din_rdy),
    .dout(dout), .dout_vld(dout_vld), .dout_last(dout_last)
  );

  parity_serializer #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .din(din2), .din_vld(din2_vld), .din_rdy(din2_rdy),
    .dout(dout2), .dout_vld(dout2_vld), .dout_last(dout2_last)
  );

  even_parity_checker u_chk (
    .clk(clk), .rst(rst), .din(dout), .din_vld(dout_vld), .dout(chk_dout)
  );

  typedef struct packed {
    logic b;
    logic last;
  } exp_t;

  exp_t q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  // Expected frame built independently: bits LSB-first, then count-of-ones parity.
  task automatic push_frame(input logic [31:0] w, input int width);
    int ones;
    ones = 0;
    for (int i = 0; i < width; i++) begin
      q.push_back('{b: w[i], last: 1'b0});
      if (w[i]) ones++;
    end
    q.push_back('{b: ones[0], last: 1'b1});
  endtask

  function automatic exp_t pop_exp();
    if (q.size() == 0) return '{b: 1'bx, last: 1'bx};
    return q.pop_front();
  endfunction

  task automatic test_reset();
    #2;
    n_vec++;
    if ({dout, dout_vld, dout_last, din_rdy, chk_dout} !== 5'b00011) begin
      n_miss++;
      $display("FAIL reset_outputs: got %b expected 00011", {dout, dout_vld, dout_last, din_rdy, chk_dout});
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if (dout_vld !== 1'b0 || din_rdy !== 1'b1) begin
      n_miss++;
      $display("FAIL idle_after_reset: vld=%b rdy=%b expected vld=0 rdy=1", dout_vld, din_rdy);
    end
  endtask

  task automatic test_single_a5();
    exp_t e;
    din = 8'hA5; din_vld = 1'b1;
    push_frame(32'hA5, 8);
    @(negedge clk);
    din_vld = 1'b0;
    for (int i = 0; i < 9; i++) begin
      e = pop_exp();
      n_vec++;
      if (dout_vld !== 1'b1 || dout !== e.b || dout_last !== e.last || din_rdy !== e.last) begin
        n_miss++;
        $display("FAIL a5_bit%0d: vld=%b dout=%b last=%b rdy=%b expected vld=1 dout=%b last=%b rdy=%b",
                 i, dout_vld, dout, dout_last, din_rdy, e.b, e.last, e.last);
      end
      @(negedge clk);
    end
    n_vec++;
    if (dout_vld !== 1'b0 || chk_dout !== 1'b1) begin
      n_miss++;
      $display("FAIL a5_end: vld=%b chk=%b expected vld=0 chk=1", dout_vld, chk_dout);
    end
  endtask

  task automatic test_bits_07();
    exp_t e;
    logic run;
    run = 1'b0;
    din = 8'h07; din_vld = 1'b1;
    push_frame(32'h07, 8);
    @(negedge clk);
    din_vld = 1'b0;
    for (int i = 0; i < 9; i++) begin
      e = pop_exp();
      n_vec++;
      if (dout_vld !== 1'b1 || dout !== e.b || dout_last !== e.last || chk_dout !== ~run) begin
        n_miss++;
        $display("FAIL 07_bit%0d: vld=%b dout=%b last=%b chk=%b expected vld=1 dout=%b last=%b chk=%b",
                 i, dout_vld, dout, dout_last, chk_dout, e.b, e.last, ~run);
      end
      run = run ^ e.b;
      @(negedge clk);
    end
    n_vec++;
    if (dout_vld !== 1'b0 || chk_dout !== 1'b1) begin
      n_miss++;
      $display("FAIL 07_end: vld=%b chk=%b expected vld=0 chk=1", dout_vld, chk_dout);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [7:0] words [3];
    int widx;
    words[0] = 8'hFF; words[1] = 8'h01; words[2] = 8'h80;
    widx = 0;
    din = words[0]; din_vld = 1'b1;
    push_frame({24'h0, words[0]}, 8);
    @(negedge clk);
    for (int i = 0; i < 27; i++) begin
      e = pop_exp();
      n_vec++;
      if (dout_vld !== 1'b1 || dout !== e.b || dout_last !== e.last) begin
        n_miss++;
        $display("FAIL b2b_cycle%0d: vld=%b dout=%b last=%b expected vld=1 dout=%b last=%b",
                 i + 1, dout_vld, dout, dout_last, e.b, e.last);
      end
      if (e.last === 1'b1) begin
        widx++;
        if (widx < 3) begin
          din = words[widx];
          push_frame({24'h0, words[widx]}, 8);
        end else begin
          din_vld = 1'b0;
        end
      end
      @(negedge clk);
    end
    n_vec++;
    if (dout_vld !== 1'b0 || chk_dout !== 1'b1 || q.size() != 0) begin
      n_miss++;
      $display("FAIL b2b_end: vld=%b chk=%b pending=%0d expected vld=0 chk=1 pending=0",
               dout_vld, chk_dout, q.size());
    end
  endtask

  task automatic test_ignore_during_data();
    exp_t e;
    din = 8'h5A; din_vld = 1'b1;
    push_frame(32'h5A, 8);
    @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      e = pop_exp();
      n_vec++;
      if (dout_vld !== 1'b1 || dout !== e.b || dout_last !== e.last || din_rdy !== e.last) begin
        n_miss++;
        $display("FAIL hold_bit%0d: vld=%b dout=%b last=%b rdy=%b expected vld=1 dout=%b last=%b rdy=%b",
                 i, dout_vld, dout, dout_last, din_rdy, e.b, e.last, e.last);
      end
      din = 8'($urandom);
      din_vld = (i < 8);
      @(negedge clk);
    end
    n_vec++;
    if (dout_vld !== 1'b0 || din_rdy !== 1'b1) begin
      n_miss++;
      $display("FAIL hold_end: vld=%b rdy=%b expected vld=0 rdy=1", dout_vld, din_rdy);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    din = 8'h3C; din_vld = 1'b1;
    push_frame(32'h3C, 8);
    @(negedge clk);
    din_vld = 1'b0;
    for (int i = 0; i < 4; i++) begin
      e = pop_exp();
      n_vec++;
      if (dout_vld !== 1'b1 || dout !== e.b) begin
        n_miss++;
        $display("FAIL rstmid_bit%0d: vld=%b dout=%b expected vld=1 dout=%b", i, dout_vld, dout, e.b);
      end
      if (i < 3) @(negedge clk);
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if (dout_vld !== 1'b0 || dout_last !== 1'b0 || din_rdy !== 1'b1) begin
      n_miss++;
      $display("FAIL rstmid_async: vld=%b last=%b rdy=%b expected vld=0 last=0 rdy=1",
               dout_vld, dout_last, din_rdy);
    end
    q.delete();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    din = 8'h01; din_vld = 1'b1;
    push_frame(32'h01, 8);
    @(negedge clk);
    din_vld = 1'b0;
    for (int i = 0; i < 9; i++) begin
      e = pop_exp();
      n_vec++;
      if (dout_vld !== 1'b1 || dout !== e.b || dout_last !== e.last) begin
        n_miss++;
        $display("FAIL after_rst_bit%0d: vld=%b dout=%b last=%b expected vld=1 dout=%b last=%b",
                 i, dout_vld, dout, dout_last, e.b, e.last);
      end
      @(negedge clk);
    end
    n_vec++;
    if (dout_vld !== 1'b0 || chk_dout !== 1'b1) begin
      n_miss++;
      $display("FAIL after_rst_end: vld=%b chk=%b expected vld=0 chk=1", dout_vld, chk_dout);
    end
  endtask

  task automatic test_width2();
    exp_t e;
    din2 = 2'b11; din2_vld = 1'b1;
    push_frame(32'h3, 2);
    @(negedge clk);
    din2_vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      e = pop_exp();
      n_vec++;
      if (dout2_vld !== 1'b1 || dout2 !== e.b || dout2_last !== e.last || u_dut2.r_cnt > 1) begin
        n_miss++;
        $display("FAIL w2_bit%0d: vld=%b dout=%b last=%b cnt=%0d expected vld=1 dout=%b last=%b cnt<=1",
                 i, dout2_vld, dout2, dout2_last, u_dut2.r_cnt, e.b, e.last);
      end
      @(negedge clk);
    end
    n_vec++;
    if (dout2_vld !== 1'b0 || din2_rdy !== 1'b1) begin
      n_miss++;
      $display("FAIL w2_end: vld=%b rdy=%b expected vld=0 rdy=1", dout2_vld, din2_rdy);
    end
  endtask

  task automatic test_zero_word();
    exp_t e;
    din = 8'h00; din_vld = 1'b1;
    push_frame(32'h0, 8);
    @(negedge clk);
    din_vld = 1'b0;
    for (int i = 0; i < 9; i++) begin
      e = pop_exp();
      n_vec++;
      if (dout_vld !== 1'b1 || dout !== e.b || dout_last !== e.last) begin
        n_miss++;
        $display("FAIL zero_bit%0d: vld=%b dout=%b last=%b expected vld=1 dout=%b last=%b",
                 i, dout_vld, dout, dout_last, e.b, e.last);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_single_a5();
    test_bits_07();
    test_back_to_back();
    test_ignore_during_data();
    test_reset_mid();
    test_width2();
    test_zero_word();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
